// File: rtl/qemu_nic_framer.sv
// qemu_nic_framer: host <-> AXIS frame bridge.
// RX serialises host-built frames, TX captures AXIS frames for the host.
module qemu_nic_framer #(
  parameter int DATAW     = 64,
  parameter int KEEPW     = DATAW/8,
  parameter int MAX_FRAME = 4096,
  parameter int WORDS     = MAX_FRAME/KEEPW,
  parameter int AW        = $clog2(WORDS)
) (
  input  logic             S_AXI_ACLK,
  input  logic             reset,
  input  logic             h_rx_wr_en,
  input  logic [DATAW-1:0] h_rx_wr_data,
  input  logic             h_rx_commit,
  input  logic [15:0]      h_rx_len,
  output logic             h_rx_ready,
  input  logic [7:0]       ifg_cycles,
  output logic [DATAW-1:0] m_axis_rx_tdata,
  output logic [KEEPW-1:0] m_axis_rx_tkeep,
  output logic             m_axis_rx_tlast,
  output logic             m_axis_rx_tvalid,
  input  logic             m_axis_rx_tready,
  input  logic [DATAW-1:0] s_axis_tx_tdata,
  input  logic [KEEPW-1:0] s_axis_tx_tkeep,
  input  logic             s_axis_tx_tlast,
  input  logic             s_axis_tx_tvalid,
  output logic             s_axis_tx_tready,
  output logic             h_tx_valid,
  output logic [15:0]      h_tx_len,
  input  logic [AW-1:0]    h_tx_rd_addr,
  output logic [DATAW-1:0] h_tx_rd_data,
  input  logic             h_tx_done,
  output logic [31:0]      rx_frames,
  output logic [31:0]      tx_frames,
  output logic [31:0]      tx_drops,
  output logic [31:0]      rx_errs
);

  localparam int KB = $clog2(KEEPW);

  typedef enum logic [1:0] {
    R_LOAD, R_SEND, R_GAP
  } rx_state_t;

  typedef enum logic [1:0] {
    T_CAPT, T_HOLD, T_DROP
  } tx_state_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] popcnt(
    input logic [KEEPW-1:0] k
  );
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < KEEPW; i++)
      c = c + 16'(k[i]);
    return c;
  endfunction

  // ---------------- RX ----------------
  rx_state_t        rx_q, rx_d;
  logic [DATAW-1:0] rx_buf [WORDS];
  logic [AW:0]      wr_ptr;
  logic [AW-1:0]    beat_idx, beats_m1;
  logic [KEEPW-1:0] keep_last;
  logic [7:0]       gap_cnt;

  logic             rx_wr_ok, commit_ev;
  logic             len_bad, commit_ok;
  logic             rx_hs, rx_done;
  logic [AW-1:0]    beats_m1_w, nxt_idx;
  logic [KB-1:0]    rem;
  logic [KEEPW-1:0] keep_last_w;
  logic [DATAW-1:0] beat0;

  assign rx_wr_ok  = h_rx_wr_en && rx_q == R_LOAD
                  && wr_ptr < (AW+1)'(WORDS);
  assign commit_ev = h_rx_commit && rx_q == R_LOAD;
  assign len_bad   = h_rx_len == 16'd0
                  || h_rx_len > 16'(MAX_FRAME);
  assign commit_ok = commit_ev && !len_bad;
  assign rx_hs     = m_axis_rx_tvalid && m_axis_rx_tready;
  assign rx_done   = rx_hs && m_axis_rx_tlast
                  && rx_q == R_SEND;

  assign beats_m1_w = AW'(((({1'b0, h_rx_len}
                    + 17'(KEEPW-1)) >> KB) - 17'd1));
  assign rem         = h_rx_len[KB-1:0];
  assign keep_last_w = (rem == '0) ? '1
                     : ~({KEEPW{1'b1}} << rem);
  assign nxt_idx     = beat_idx + AW'(1);
  // A word written in the commit cycle is not in the RAM yet.
  assign beat0 = (rx_wr_ok && wr_ptr == '0)
               ? h_rx_wr_data : rx_buf[0];

  // RX state register
  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) rx_q <= R_LOAD;
    else       rx_q <= rx_d;
  end

  // RX next-state logic
  always_comb begin
    rx_d = rx_q;
    unique case (1'b1)
      (rx_q == R_LOAD):
        if (commit_ok) rx_d = R_SEND;
      (rx_q == R_SEND):
        if (rx_done)
          rx_d = (ifg_cycles == 8'd0) ? R_LOAD : R_GAP;
      (rx_q == R_GAP):
        if (gap_cnt <= 8'd1) rx_d = R_LOAD;
      default: rx_d = R_LOAD;
    endcase
  end

  // RX frame buffer write port
  always_ff @(posedge S_AXI_ACLK) begin
    if (rx_wr_ok) rx_buf[wr_ptr[AW-1:0]] <= h_rx_wr_data;
  end

  // RX pointers, AXIS master beats, gap timer, counters
  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) begin
      h_rx_ready       <= 1'b0;
      wr_ptr           <= '0;
      beat_idx         <= '0;
      beats_m1         <= '0;
      keep_last        <= '0;
      gap_cnt          <= '0;
      m_axis_rx_tvalid <= 1'b0;
      m_axis_rx_tdata  <= '0;
      m_axis_rx_tkeep  <= '0;
      m_axis_rx_tlast  <= 1'b0;
      rx_frames        <= '0;
      rx_errs          <= '0;
    end else begin
      h_rx_ready <= (rx_d == R_LOAD);
      if (commit_ev)     wr_ptr <= '0;
      else if (rx_wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (commit_ev && len_bad)
        rx_errs <= sat_inc(rx_errs);
      if (commit_ok) begin
        beat_idx         <= '0;
        beats_m1         <= beats_m1_w;
        keep_last        <= keep_last_w;
        m_axis_rx_tvalid <= 1'b1;
        m_axis_rx_tdata  <= beat0;
        m_axis_rx_tlast  <= (beats_m1_w == '0);
        m_axis_rx_tkeep  <= (beats_m1_w == '0)
                          ? keep_last_w : '1;
      end else if (rx_q == R_SEND && rx_hs) begin
        if (m_axis_rx_tlast) begin
          m_axis_rx_tvalid <= 1'b0;
          rx_frames        <= sat_inc(rx_frames);
          gap_cnt          <= ifg_cycles;
        end else begin
          beat_idx        <= nxt_idx;
          m_axis_rx_tdata <= rx_buf[nxt_idx];
          m_axis_rx_tlast <= (nxt_idx == beats_m1);
          m_axis_rx_tkeep <= (nxt_idx == beats_m1)
                           ? keep_last : '1;
        end
      end
      if (rx_q == R_GAP) gap_cnt <= gap_cnt - 8'd1;
    end
  end

  // ---------------- TX ----------------
  tx_state_t        tx_q, tx_d;
  logic [DATAW-1:0] tx_buf [WORDS];
  logic [AW-1:0]    tx_ptr;
  logic [15:0]      tx_bytes, beat_bytes;
  logic             tx_hs, tx_full;

  assign tx_hs      = s_axis_tx_tvalid && s_axis_tx_tready;
  assign tx_full    = tx_ptr == AW'(WORDS-1);
  assign beat_bytes = popcnt(s_axis_tx_tkeep);

  // TX state register
  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) tx_q <= T_CAPT;
    else       tx_q <= tx_d;
  end

  // TX next-state logic
  always_comb begin
    tx_d = tx_q;
    unique case (1'b1)
      (tx_q == T_CAPT):
        if (tx_hs) begin
          if (s_axis_tx_tlast) tx_d = T_HOLD;
          else if (tx_full)    tx_d = T_DROP;
        end
      (tx_q == T_HOLD):
        if (h_tx_done) tx_d = T_CAPT;
      (tx_q == T_DROP):
        if (tx_hs && s_axis_tx_tlast) tx_d = T_CAPT;
      default: tx_d = T_CAPT;
    endcase
  end

  // TX frame buffer write port
  always_ff @(posedge S_AXI_ACLK) begin
    if (tx_q == T_CAPT && tx_hs)
      tx_buf[tx_ptr] <= s_axis_tx_tdata;
  end

  // TX capture, host handoff, read port, counters
  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) begin
      s_axis_tx_tready <= 1'b0;
      tx_ptr           <= '0;
      tx_bytes         <= '0;
      h_tx_valid       <= 1'b0;
      h_tx_len         <= '0;
      h_tx_rd_data     <= '0;
      tx_frames        <= '0;
      tx_drops         <= '0;
    end else begin
      s_axis_tx_tready <= (tx_d != T_HOLD);
      if (tx_q == T_CAPT && tx_hs) begin
        tx_ptr   <= tx_ptr + AW'(1);
        tx_bytes <= tx_bytes + beat_bytes;
        if (s_axis_tx_tlast) begin
          h_tx_len   <= tx_bytes + beat_bytes;
          h_tx_valid <= 1'b1;
          tx_frames  <= sat_inc(tx_frames);
        end
      end
      if (tx_q == T_DROP && tx_hs && s_axis_tx_tlast) begin
        tx_drops <= sat_inc(tx_drops);
        tx_ptr   <= '0;
        tx_bytes <= '0;
      end
      if (tx_q == T_HOLD) begin
        h_tx_rd_data <= tx_buf[h_tx_rd_addr];
        if (h_tx_done) begin
          h_tx_valid <= 1'b0;
          tx_ptr     <= '0;
          tx_bytes   <= '0;
        end
      end
    end
  end

endmodule
